demux2_stream: RTL and testbench
================================

// Module: demux2_stream
//
// PURPOSE
//   Sequential counterpart of the 2:1 word multiplexer. Routes a stream of
//   WIDTH-bit words from one valid/ready input port to one of two output ports.
//   The destination is chosen per packet: s is sampled on the first beat and
//   held until the beat flagged 'last'. Each output has its own FIFO, so a
//   stalled consumer on one side does not corrupt the other. Per-output beat
//   counters are provided for bench checking.
//
// PARAMETERS
//   WIDTH  4  data word width, in bits
//   DEPTH  2  entries per output FIFO; power of 2, >= 2
//   CNT_W  8  width of each delivered-beat counter
//
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   d          in   WIDTH  input data word
//   s          in   1      destination select (0 -> y0, 1 -> y1); sampled on the first beat only
//   last       in   1      marks the final beat of a packet
//   in_valid   in   1      input beat present
//   in_ready   out  1      block accepts the input beat this cycle
//   y0         out  WIDTH  output 0 data (head of FIFO0)
//   y0_valid   out  1      FIFO0 not empty
//   y0_ready   in   1      consumer 0 takes y0
//   y1         out  WIDTH  output 1 data (head of FIFO1)
//   y1_valid   out  1      FIFO1 not empty
//   y1_ready   in   1      consumer 1 takes y1
//   cnt0       out  CNT_W  beats delivered on output 0
//   cnt1       out  CNT_W  beats delivered on output 1
//   busy       out  1      a packet is open (state != IDLE)
//
// BEHAVIOUR
//   - Reset (asynchronous, reset_n=0): state=IDLE; both FIFOs flushed;
//     y0_valid=y1_valid=0; y0=y1=0; cnt0=cnt1=0; busy=0. in_ready=0 while reset_n=0.
//     Reset asserted mid-packet discards the open packet and all buffered words.
//   - Definitions:
//       accept = in_valid & in_ready
//       pop_k  = yk_valid & yk_ready
//   - FSM states: IDLE, ROUTE0, ROUTE1.
//       IDLE:  dest = s.
//              On accept with last=0 -> ROUTE<s>.
//              On accept with last=1 -> stay IDLE (single-beat packet).
//       ROUTEk: dest = k; s is ignored.
//              On accept with last=1 -> IDLE. Otherwise stay in ROUTEk.
//   - in_ready = !full(FIFO[dest]). Readiness is based only on the occupancy
//     of the destination FIFO; a same-cycle pop gives no credit.
//   - On accept, d is written into FIFO[dest].
//   - Latency: a word accepted at edge N is visible on yk with yk_valid=1 after
//     edge N, provided FIFOk was empty. There is no combinational path from d to yk.
//   - Outputs: yk/yk_valid are driven from FIFO head registers. yk holds its
//     value while yk_valid=1 and yk_ready=0. Word order is preserved per output.
//   - Simultaneous push and pop on the same FIFO: both take effect and
//     occupancy is unchanged.
//   - Full FIFO: in_ready=0. The input must hold d/s/last stable until accepted.
//   - Empty FIFO: yk_valid=0. yk_ready is ignored and yk keeps the last popped value.
//   - Pointers wrap modulo DEPTH. Occupancy is tracked in a separate
//     log2(DEPTH)+1-bit count.
//   - Counters: cntk increments by 1 on each pop_k and wraps from 2^CNT_W-1 to 0.
//   - busy = (state != IDLE), registered.
//
// TESTING
//   1. Reset: reset_n=0 asserted asynchronously mid-cycle -> all outputs are 0
//      immediately, including in_ready. Release reset_n -> in_ready=1 at the next edge.
//   2. Single beats: d=4'h0,s=0,last=1, then d=4'hF,s=1,last=1, both consumers
//      ready -> y0=4'h0 one cycle after accept, y1=4'hF after the next;
//      cnt0=cnt1=1.
//   3. Packet lock: 3-beat packet 4'hA,4'hB,4'hC with s=1,0,0 on the beats ->
//      all three beats appear on y1 in order; busy=1 until the beat with last=1.
//   4. Backpressure: y0_ready=0, push DEPTH+1 beats to output 0 -> in_ready=0
//      after DEPTH accepts, y0=first word held. Raise y0_ready -> the remaining
//      beat drains and no word is lost.
//   5. Isolation: y1_ready=0 with FIFO1 full; a new IDLE packet with s=0 ->
//      in_ready=1 and data flows to y0 unaffected.
//   6. Wrap: 2^CNT_W+3 pops on y0 -> cnt0=3. Reset asserted mid-packet ->
//      buffered words discarded, state=IDLE.

Source files
------------

// File: rtl/demux2_stream.sv
// -----------------------------------------------------------------------------
// demux2_stream
//   Routes a valid/ready stream of WIDTH-bit words to one of two outputs.
//   The destination is picked on the first beat of each packet from 's'. It is
//   then held until the beat flagged 'last' is accepted. Each output has its
//   own DEPTH-entry FIFO, so a stalled consumer only blocks packets that are
//   headed for it. Each output also counts the beats it delivers.
//
//   Ports
//     clk, reset_n      rising-edge clock, asynchronous active-low reset
//     d, s, last        input word, destination select, end-of-packet flag
//     in_valid/ready    input handshake
//     y0, y0_valid      output 0 head word / FIFO0 not empty
//     y0_ready          consumer 0 takes y0
//     y1, y1_valid      output 1 head word / FIFO1 not empty
//     y1_ready          consumer 1 takes y1
//     cnt0, cnt1        wrapping counts of beats delivered per output
//     busy              a packet is open (registered)
// -----------------------------------------------------------------------------

// Per-output FIFO with head hold register and delivered-beat counter.
//   push_i/wdata_i  write port (caller only pushes when !full_o)
//   ready_i         consumer ready; a pop happens when valid_o & ready_i
//   full_o/valid_o  occupancy flags
//   data_o          head word, or the last popped word while empty
//   cnt_o           wrapping count of pops
module demux2_stream_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             ready_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;

   assign valid_o = (occ_q != '0);
   assign full_o  = (occ_q == OW'(DEPTH));
   assign pop     = valid_o & ready_i;
   // While empty the output shows the last word that left, not stale storage.
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;
   assign cnt_o   = cnt_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         hold_d   = mem_q[rd_ptr_q];
         cnt_d    = cnt_q + CNT_W'(1);
      end
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      // Push and pop in the same cycle leave the occupancy unchanged.
      case ({push_i, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: it is only visible through valid entries.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end
endmodule

module demux2_stream #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   input  logic             s,
   input  logic             last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y0,
   output logic             y0_valid,
   input  logic             y0_ready,
   output logic [WIDTH-1:0] y1,
   output logic             y1_valid,
   input  logic             y1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;

   state_t state_q, state_d;
   logic   busy_q, busy_d;
   logic   en_q;
   logic   dest;
   logic   full0, full1;
   logic   accept;
   logic   push0, push1;

   // Input readiness looks only at the destination FIFO's occupancy. en_q
   // keeps the input closed during reset and up to the first edge after it.
   assign in_ready = en_q & ~(dest ? full1 : full0);
   assign accept   = in_valid & in_ready;
   assign push0    = accept & ~dest;
   assign push1    = accept & dest;
   assign busy     = busy_q;

   always_comb begin
      state_d = state_q;
      dest    = s;
      case (state_q)
         IDLE: begin
            dest = s;
            if (accept && !last) begin
               state_d = s ? ROUTE1 : ROUTE0;
            end
         end
         ROUTE0: begin
            dest = 1'b0;
            if (accept && last) begin
               state_d = IDLE;
            end
         end
         ROUTE1: begin
            dest = 1'b1;
            if (accept && last) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         en_q    <= 1'b1;
      end
   end

   demux2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo0 (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push0),
      .wdata_i (d),
      .ready_i (y0_ready),
      .full_o  (full0),
      .valid_o (y0_valid),
      .data_o  (y0),
      .cnt_o   (cnt0)
   );

   demux2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo1 (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push1),
      .wdata_i (d),
      .ready_i (y1_ready),
      .full_o  (full1),
      .valid_o (y1_valid),
      .data_o  (y1),
      .cnt_o   (cnt1)
   );
endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: a vector table, directed corner sequences and a
// randomized run checked against a queue-based model of the two outputs.
module tb_demux2_stream;
   localparam int WIDTH = 4;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [WIDTH-1:0] d = '0;
   logic             s = 1'b0;
   logic             last = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] y0, y1;
   logic             y0_valid, y1_valid;
   logic             y0_ready = 1'b0;
   logic             y1_ready = 1'b0;
   logic [CNT_W-1:0] cnt0, cnt1;
   logic             busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .d        (d),
      .s        (s),
      .last     (last),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y0       (y0),
      .y0_valid (y0_valid),
      .y0_ready (y0_ready),
      .y1       (y1),
      .y1_valid (y1_valid),
      .y1_ready (y1_ready),
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .busy     (busy)
   );

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       s;
      logic       last;
      logic       r0;
      logic       r1;
      logic       e_rdy;
      logic       e_y0v;
      logic [3:0] e_y0;
      logic       e_y1v;
      logic [3:0] e_y1;
      logic       e_busy;
      logic [7:0] e_c0;
      logic [7:0] e_c1;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] dd, input logic ss, input logic ll,
                        input logic r0, input logic r1);
      in_valid = v;
      d        = dd;
      s        = ss;
      last     = ll;
      y0_ready = r0;
      y1_ready = r1;
   endtask

   task automatic chk_out(input string tag, input logic e_y0v, input logic [3:0] e_y0,
                          input logic e_y1v, input logic [3:0] e_y1, input logic e_busy,
                          input logic [7:0] e_c0, input logic [7:0] e_c1);
      chk({tag, ".y0_valid"}, y0_valid, e_y0v);
      chk({tag, ".y0"}, y0, e_y0);
      chk({tag, ".y1_valid"}, y1_valid, e_y1v);
      chk({tag, ".y1"}, y1, e_y1);
      chk({tag, ".busy"}, busy, e_busy);
      chk({tag, ".cnt0"}, cnt0, e_c0);
      chk({tag, ".cnt1"}, cnt1, e_c1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".in_ready"}, in_ready, 1'b0);
      chk_out(tag, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0);
   endtask

   // Reset pulse ending with the input opened at a clock edge.
   task automatic do_reset;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick;
   endtask

   // Random-phase reference model: the two outputs are plain queues.
   logic [3:0] q0[$];
   logic [3:0] q1[$];
   logic [3:0] h0, h1;
   int         mc0, mc1;
   bit         pkt_open;
   bit         pkt_dest;

   initial begin
      // Reset asserted asynchronously in the middle of a cycle.
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_reset("rst_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("rst_release_pre_edge", in_ready, 1'b0);
      tick;
      chk("rst_release_rdy", in_ready, 1'b1);

      // Single beats and a three-beat packet locked to y1.
      tbl[0] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0};
      tbl[1] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 8'd1, 8'd0};
      tbl[2] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 8'd1, 8'd1};
      tbl[3] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 8'd1, 8'd1};
      tbl[4] = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hB, 1'b1, 8'd1, 8'd2};
      tbl[5] = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hC, 1'b0, 8'd1, 8'd3};
      tbl[6] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hC, 1'b0, 8'd1, 8'd4};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].last, tbl[i].r0, tbl[i].r1);
         #1 chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].e_rdy);
         tick;
         chk_out($sformatf("tbl%0d", i), tbl[i].e_y0v, tbl[i].e_y0, tbl[i].e_y1v, tbl[i].e_y1,
                 tbl[i].e_busy, tbl[i].e_c0, tbl[i].e_c1);
      end

      // Backpressure on output 0: DEPTH+1 beats, consumer stalled.
      drive(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
      #1 chk("bp.rdy1", in_ready, 1'b1);
      tick;
      drive(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1);
      #1 chk("bp.rdy2", in_ready, 1'b1);
      tick;
      drive(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1);
      #1 chk("bp.full", in_ready, 1'b0);
      tick;
      chk_out("bp.held", 1'b1, 4'h1, 1'b0, 4'hC, 1'b0, 8'd1, 8'd4);
      drive(1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1);
      #1 chk("bp.no_pop_credit", in_ready, 1'b0);
      tick;
      chk_out("bp.pop1", 1'b1, 4'h2, 1'b0, 4'hC, 1'b0, 8'd2, 8'd4);
      #1 chk("bp.rdy_after_pop", in_ready, 1'b1);
      tick;
      chk_out("bp.pop2", 1'b1, 4'h3, 1'b0, 4'hC, 1'b0, 8'd3, 8'd4);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick;
      chk_out("bp.drained", 1'b0, 4'h3, 1'b0, 4'hC, 1'b0, 8'd4, 8'd4);

      // Isolation: FIFO1 full and stalled, output 0 keeps flowing.
      drive(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
      tick;
      drive(1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 1'b0);
      tick;
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 chk("iso.full1_blocks", in_ready, 1'b0);
      drive(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
      #1 chk("iso.rdy0", in_ready, 1'b1);
      tick;
      chk_out("iso.flow", 1'b1, 4'h7, 1'b1, 4'h5, 1'b0, 8'd4, 8'd4);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick;
      chk_out("iso.drain1", 1'b0, 4'h7, 1'b1, 4'h6, 1'b0, 8'd5, 8'd5);
      tick;
      chk_out("iso.drain2", 1'b0, 4'h7, 1'b0, 4'h6, 1'b0, 8'd5, 8'd6);

      // Counter wrap: 2^CNT_W+3 pops on output 0.
      do_reset();
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         drive(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b1);
         tick;
      end
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick;
      chk_out("wrap", 1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 8'd3, 8'd0);

      // Reset in the middle of an open packet with words buffered.
      drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
      tick;
      drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
      tick;
      chk("midrst.busy_before", busy, 1'b1);
      chk("midrst.y1v_before", y1_valid, 1'b1);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_reset("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("midrst.rdy_pre_edge", in_ready, 1'b0);
      tick;
      chk("midrst.rdy_post_edge", in_ready, 1'b1);
      drive(1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
      tick;
      chk_out("midrst.idle", 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0);

      // Randomized traffic against the queue model.
      do_reset();
      q0.delete();
      q1.delete();
      h0 = '0;
      h1 = '0;
      mc0 = 0;
      mc1 = 0;
      pkt_open = 1'b0;
      pkt_dest = 1'b0;
      begin
         logic       rv, rs, rl;
         logic [3:0] rd;
         bit         pending;
         pending = 1'b0;
         rv = 1'b0; rs = 1'b0; rl = 1'b0; rd = '0;
         for (int c = 0; c < 400; c++) begin
            bit dst, exp_rdy, acc, p0, p1;
            logic r0, r1;
            if (!pending) begin
               rv = (($urandom % 4) != 0);
               rd = 4'($urandom);
               rs = 1'($urandom);
               rl = (($urandom % 3) == 0);
            end
            r0 = (($urandom % 3) != 0);
            r1 = (($urandom % 3) != 0);
            drive(rv, rd, rs, rl, r0, r1);
            dst     = pkt_open ? pkt_dest : rs;
            exp_rdy = ((dst ? q1.size() : q0.size()) < DEPTH);
            #1 chk($sformatf("rnd%0d.in_ready", c), in_ready, exp_rdy);
            acc = rv && exp_rdy;
            p0  = (q0.size() != 0) && r0;
            p1  = (q1.size() != 0) && r1;
            pending = rv && !acc;
            tick;
            if (p0) begin
               h0  = q0.pop_front();
               mc0 = (mc0 + 1) % (1 << CNT_W);
            end
            if (p1) begin
               h1  = q1.pop_front();
               mc1 = (mc1 + 1) % (1 << CNT_W);
            end
            if (acc) begin
               if (dst) q1.push_back(rd);
               else     q0.push_back(rd);
               if (rl) begin
                  pkt_open = 1'b0;
               end else begin
                  pkt_open = 1'b1;
                  pkt_dest = dst;
               end
            end
            chk_out($sformatf("rnd%0d", c),
                    q0.size() != 0, (q0.size() != 0) ? q0[0] : h0,
                    q1.size() != 0, (q1.size() != 0) ? q1[0] : h1,
                    pkt_open, 8'(mc0), 8'(mc1));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
